// File: rtl/alu_arbiter.sv
// Arbitrates NUM_REQ requesters onto one external ALU with a single operation in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; default is round-robin.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ALU_LAT = 1,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_vld,
    input  logic [2*NUM_REQ-1:0]   req_op,
    input  logic [8*NUM_REQ-1:0]   req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]     req_rdy,
    output logic                   rsp_vld,
    input  logic                   rsp_rdy,
    output logic [IDW-1:0]         rsp_id,
    output logic [15:0]            rsp_data,
    output logic [1:0]             alu_op,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic                   alu_vld,
    input  logic [15:0]            alu_out,
    output logic [15:0]            stat_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_r;
    logic [IDW-1:0]       ptr_r;
    logic [IDW-1:0]       sel_id_r;
    logic [3:0]           wait_cnt_r;

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic                 win_found_s;
    logic [IDW-1:0]       win_id_s;
    logic [1:0]           win_op_s;
    logic [7:0]           win_a_s;
    logic [7:0]           win_b_s;
    int                   pos_s;

    // Winner search: rotate requests so bit 0 is the pointer position, take the first set bit.
    always_comb begin
        dbl_s       = {req_vld, req_vld} >> ptr_r;
        rot_s       = dbl_s[NUM_REQ-1:0];
        win_found_s = 1'b0;
        win_id_s    = '0;
        pos_s       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found_s && rot_s[k]) begin
                win_found_s = 1'b1;
                pos_s       = int'(ptr_r) + k;
                if (pos_s >= NUM_REQ) begin
                    pos_s = pos_s - NUM_REQ;
                end else begin
                    pos_s = pos_s;
                end
                win_id_s = IDW'(pos_s);
            end else begin
                win_found_s = win_found_s;
            end
        end
        win_op_s = 2'(req_op >> {win_id_s, 1'b0});
        win_a_s  = 8'(req_a >> {win_id_s, 3'b000});
        win_b_s  = 8'(req_b >> {win_id_s, 3'b000});
    end

    // Grant is combinational so the requester sees its accept in the same cycle it is chosen.
    always_comb begin
        if (!rst && (state_r == S_IDLE) && win_found_s) begin
            req_rdy = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id_s;
        end else begin
            req_rdy = '0;
        end
    end

    // Control FSM with all datapath and response outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            ptr_r      <= '0;
            sel_id_r   <= '0;
            wait_cnt_r <= 4'd0;
            rsp_vld    <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= 16'd0;
            alu_op     <= 2'd0;
            alu_a      <= 8'd0;
            alu_b      <= 8'd0;
            alu_vld    <= 1'b0;
            stat_cnt   <= 16'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (win_found_s) begin
                        sel_id_r <= win_id_s;
                        alu_op   <= win_op_s;
                        alu_a    <= win_a_s;
                        alu_b    <= win_b_s;
                        alu_vld  <= 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
                        ptr_r    <= '0;
`else
                        ptr_r    <= (win_id_s == IDW'(NUM_REQ - 1)) ? '0 : win_id_s + 1'b1;
`endif
                        state_r  <= S_ISSUE;
                    end else begin
                        alu_vld  <= 1'b0;
                        state_r  <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    alu_vld    <= 1'b0;
                    wait_cnt_r <= 4'(ALU_LAT - 1);
                    state_r    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_r == 4'd0) begin
                        rsp_data <= alu_out;
                        rsp_id   <= sel_id_r;
                        rsp_vld  <= 1'b1;
                        state_r  <= S_RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        state_r <= S_IDLE;
                        if (stat_cnt != 16'hFFFF) begin
                            stat_cnt <= stat_cnt + 16'd1;
                        end else begin
                            stat_cnt <= stat_cnt;
                        end
                    end else begin
                        state_r <= S_RESP;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    rsp_vld <= 1'b0;
                    alu_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (legal 2..8); IDW = clog2(NUM_REQ).
REQ-002 SHALL have parameter ALU_LAT, default 1, ALU cycles from ALU_VLD sampled to ALU_OUT valid (legal 1..15).
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 REQ_VLD  input  NUM_REQ  per-requester operation request.
REQ-006 REQ_OP  input  2*NUM_REQ  opcode of requester i at bits [2i+1:2i].
REQ-007 REQ_A / REQ_B  input  8*NUM_REQ  operands of requester i at bits [8i+7:8i].
REQ-008 REQ_RDY  output  NUM_REQ  one-hot grant; request i accepted when REQ_VLD[i] and REQ_RDY[i] are both 1.
REQ-009 RSP_VLD  output  1  response valid; RSP_RDY  input  1  response accepted.
REQ-010 RSP_ID  output  IDW  index of the requester that owns RSP_DATA.
REQ-011 RSP_DATA  output  16  ALU result.
REQ-012 ALU_OP  output  2; ALU_A / ALU_B  output  8  operands to the ALU; ALU_VLD  output  1  issue strobe.
REQ-013 ALU_OUT  input  16  ALU result; the ALU's OV flag SHALL NOT be used (result timing is by ALU_LAT only).
REQ-014 STAT_CNT  output  16  completed-response counter.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; one operation in flight at a time.
REQ-016 IDLE: if any REQ_VLD set, SHALL assert REQ_RDY for exactly one winner combinationally in that cycle, capture its OP/A/B/index into registers, go to ISSUE; else stay IDLE.
REQ-017 REQ_RDY SHALL be all-zero in every state other than IDLE and whenever REQ_VLD is all-zero.
REQ-018 ISSUE: ALU_VLD=1 for exactly one cycle with captured ALU_OP/ALU_A/ALU_B; load wait counter with ALU_LAT-1; go to WAIT.
REQ-019 ALU_OP/ALU_A/ALU_B SHALL hold captured values from ISSUE until the next grant; ALU_VLD=0 outside ISSUE.
REQ-020 WAIT: counter decrements each cycle; in the cycle counter==0, SHALL register ALU_OUT into RSP_DATA and go to RESP.
REQ-021 Latency: with ALU_LAT=1, grant in cycle t, ALU_VLD in t+1, RSP_VLD first high in t+3; generally t+2+ALU_LAT.
REQ-022 RESP: RSP_VLD=1 with RSP_ID/RSP_DATA stable until RSP_RDY=1; on that cycle go to IDLE, increment STAT_CNT.
REQ-023 RSP_VLD=1 with RSP_RDY=1 in the first RESP cycle SHALL complete in one cycle; next grant possible the cycle after.
REQ-024 STAT_CNT SHALL saturate at 16'hFFFF (no wrap).
REQ-025 Opcodes and operands SHALL pass through unmodified; result width 16 bits, no truncation or sign handling.
REQ-026 Round-robin (default arbitration): search starts at pointer P, wraps NUM_REQ-1 -> 0; on grant, P = winner+1 mod NUM_REQ.
REQ-027 A requester deasserting REQ_VLD before grant SHALL simply lose eligibility; no error, no pointer change.

Reset
REQ-028 While RST=1 at a clock edge: state IDLE, P=0, counter 0, REQ_RDY=0, RSP_VLD=0, RSP_ID=0, RSP_DATA=0, ALU_VLD=0, ALU_OP=0, ALU_A=0, ALU_B=0, STAT_CNT=0.
REQ-029 RST during ISSUE/WAIT/RESP SHALL abandon the operation; no response issued for it afterwards, STAT_CNT not incremented.
REQ-030 REQ_RDY SHALL be 0 in any cycle where RST=1.

Configuration
REQ-031 Macro ALU_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, pointer P unused (held 0).
REQ-032 ALU_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-026; all other behaviour identical.

Verification
REQ-033 Single op: RST then REQ_VLD=0001, OP=00, A=8'h12, B=8'h34 -> REQ_RDY=0001 same cycle, ALU_VLD 1 cycle later, RSP_VLD 3 cycles after grant, RSP_ID=0, RSP_DATA=ALU_OUT, STAT_CNT=1.
REQ-034 Round-robin fairness: REQ_VLD=1111 held, RSP_RDY=1 -> grant order 0,1,2,3,0; with ALU_ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-035 Backpressure: RSP_RDY=0 for 5 cycles in RESP -> RSP_VLD/RSP_ID/RSP_DATA stable, REQ_RDY=0000 despite REQ_VLD=1111.
REQ-036 Reset mid-op: RST=1 in WAIT cycle -> next cycle all outputs zero, no RSP_VLD ever for abandoned op, STAT_CNT=0.
REQ-037 ALU_LAT=3 with OP=11, A=8'hF0, B=8'h3C -> RSP_VLD first high 5 cycles after grant, RSP_DATA=16'h0030.
REQ-038 Saturation: force 65536 completions -> STAT_CNT stays 16'hFFFF.
